// File: rtl/sort_ctrl.sv
// Selection-sort sequencer: walks outer index i and inner index j over an
// external 1R/1W word memory, tracks the running minimum and issues a
// two-write swap whenever the minimum is not already at position i.
module sort_ctrl #(
    parameter int unsigned DATAWIDTH = 32,
    parameter int unsigned DEPTH     = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [DATAWIDTH-1:0] rd_data,
    output logic [DATAWIDTH-1:0] a,
    output logic [DATAWIDTH-1:0] b,
    output logic                 sel_add,
    output logic                 wr_en,
    output logic [DATAWIDTH-1:0] wr_addr,
    output logic [DATAWIDTH-1:0] wr_data,
    output logic                 busy,
    output logic                 done
);

    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IW-1:0] LAST_J = IW'(DEPTH - 1);
    localparam logic [IW-1:0] LAST_I = IW'(DEPTH - 2);

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        RD_I   = 4'd1,
        LD_I   = 4'd2,
        RD_J   = 4'd3,
        CMP_J  = 4'd4,
        SWAP_A = 4'd5,
        SWAP_B = 4'd6,
        NEXT_I = 4'd7,
        DONE   = 4'd8
    } state_t;

    state_t                state_q, state_n;
    logic [IW-1:0]         i_q, i_n;
    logic [IW-1:0]         j_q, j_n;
    logic [IW-1:0]         min_idx_q, min_idx_n;
    logic [DATAWIDTH-1:0]  min_val_q, min_val_n;
    logic [DATAWIDTH-1:0]  val_i_q, val_i_n;

    logic                  sel_add_q, sel_add_n;
    logic                  wr_en_q, wr_en_n;
    logic [DATAWIDTH-1:0]  wr_addr_q, wr_addr_n;
    logic [DATAWIDTH-1:0]  wr_data_q, wr_data_n;
    logic                  busy_q, busy_n;
    logic                  done_q, done_n;

    // Next-state, datapath updates, and outputs decoded from the state being entered
    always_comb begin
        state_n   = state_q;
        i_n       = i_q;
        j_n       = j_q;
        min_idx_n = min_idx_q;
        min_val_n = min_val_q;
        val_i_n   = val_i_q;
        sel_add_n = 1'b0;
        wr_en_n   = 1'b0;
        wr_addr_n = '0;
        wr_data_n = '0;
        busy_n    = 1'b0;
        done_n    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    i_n     = '0;
                    state_n = RD_I;
                end
            end
            RD_I: state_n = LD_I;
            LD_I: begin
                val_i_n   = rd_data;
                min_val_n = rd_data;
                min_idx_n = i_q;
                j_n       = i_q + IW'(1);
                state_n   = RD_J;
            end
            RD_J: state_n = CMP_J;
            CMP_J: begin
                if (rd_data < min_val_q) begin
                    min_val_n = rd_data;
                    min_idx_n = j_q;
                end
                if (j_q != LAST_J) begin
                    j_n     = j_q + IW'(1);
                    state_n = RD_J;
                end else begin
                    state_n = (min_idx_n != i_q) ? SWAP_A : NEXT_I;
                end
            end
            SWAP_A: state_n = SWAP_B;
            SWAP_B: state_n = NEXT_I;
            NEXT_I: begin
                if (i_q == LAST_I) begin
                    state_n = DONE;
                end else begin
                    i_n     = i_q + IW'(1);
                    state_n = RD_I;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase

        case (state_n)
            RD_J, CMP_J: sel_add_n = 1'b1;
            SWAP_A: begin
                wr_en_n   = 1'b1;
                wr_addr_n = DATAWIDTH'(min_idx_n);
                wr_data_n = val_i_n;
            end
            SWAP_B: begin
                wr_en_n   = 1'b1;
                wr_addr_n = DATAWIDTH'(i_n);
                wr_data_n = min_val_n;
            end
            DONE:    done_n = 1'b1;
            default: ;
        endcase

        busy_n = (state_n != IDLE) && (state_n != DONE);
    end

    // State, datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            i_q       <= '0;
            j_q       <= '0;
            min_idx_q <= '0;
            min_val_q <= '0;
            val_i_q   <= '0;
            sel_add_q <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_n;
            i_q       <= i_n;
            j_q       <= j_n;
            min_idx_q <= min_idx_n;
            min_val_q <= min_val_n;
            val_i_q   <= val_i_n;
            sel_add_q <= sel_add_n;
            wr_en_q   <= wr_en_n;
            wr_addr_q <= wr_addr_n;
            wr_data_q <= wr_data_n;
            busy_q    <= busy_n;
            done_q    <= done_n;
        end
    end

    assign a       = DATAWIDTH'(i_q);
    assign b       = DATAWIDTH'(j_q);
    assign sel_add = sel_add_q;
    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule
